// File: rtl/ahb_to_apb_bridge.sv
// AHB-Lite slave to APB4 master bridge: one transfer in flight, AHB and APB share PCLK.
// Illegal size/alignment, APB slave errors and PREADY timeouts end in a two-cycle AHB ERROR.
module ahb_to_apb_bridge #(
  parameter int unsigned TIMEOUT = 0
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [3:0]  HPROT,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  output logic [3:0]  PSTRB,
  output logic [2:0]  PPROT,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WDATA  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR1   = 3'd5,
    ST_ERR2   = 3'd6
  } state_t;

  localparam logic [16:0] TIMEOUT_W  = 17'(TIMEOUT);
  localparam logic        TIMEOUT_EN = (TIMEOUT != 32'd0);

  function automatic logic size_ok_f(input logic [2:0] size, input logic [1:0] lsb);
    logic ok;
    case (size)
      3'd0:    ok = 1'b1;
      3'd1:    ok = (lsb[0] == 1'b0);
      3'd2:    ok = (lsb == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] strb_f(input logic write, input logic [2:0] size,
                                        input logic [1:0] lsb);
    logic [3:0] s;
    if (!write) begin
      s = 4'b0000;
    end else begin
      case (size)
        3'd0:    s = 4'b0001 << lsb;
        3'd1:    s = 4'b0011 << {lsb[1], 1'b0};
        3'd2:    s = 4'b1111;
        default: s = 4'b0000;
      endcase
    end
    return s;
  endfunction

  state_t      state_r;
  state_t      state_s;
  logic [15:0] wait_cnt_r;
  logic        cap_phase_s;
  logic        cap_s;
  logic        timeout_hit_s;

  logic        psel_r;
  logic        penable_r;
  logic        pwrite_r;
  logic [31:0] paddr_r;
  logic [31:0] pwdata_r;
  logic [3:0]  pstrb_r;
  logic [2:0]  pprot_r;
  logic        hreadyout_r;
  logic        hresp_r;
  logic [31:0] hrdata_r;

  logic unused_s;
  assign unused_s = ^{HTRANS[0], HPROT[3:2]};

  assign cap_phase_s   = (state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_ERR2);
  assign cap_s         = cap_phase_s && HSEL && HTRANS[1] && HREADY;
  assign timeout_hit_s = TIMEOUT_EN && (({1'b0, wait_cnt_r} + 17'd1) == TIMEOUT_W);

  // Next-state decode for the transfer sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        if (cap_s) begin
          if (!size_ok_f(HSIZE, HADDR[1:0])) begin
            state_s = ST_ERR1;
          end else if (HWRITE) begin
            state_s = ST_WDATA;
          end else begin
            state_s = ST_SETUP;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WDATA:  state_s = ST_SETUP;
      ST_SETUP:  state_s = ST_ACCESS;
      ST_ACCESS: begin
        if (PREADY) begin
          if (PSLVERR) begin
            state_s = ST_ERR1;
          end else begin
            state_s = ST_DONE;
          end
        end else if (timeout_hit_s) begin
          state_s = ST_ERR1;
        end else begin
          state_s = ST_ACCESS;
        end
      end
      ST_ERR1:   state_s = ST_ERR2;
      default:   state_s = ST_IDLE;
    endcase
  end

  // State register and saturating PREADY wait counter (zero outside ACCESS).
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= 16'd0;
    end else begin
      state_r <= state_s;
      if (state_r != ST_ACCESS) begin
        wait_cnt_r <= 16'd0;
      end else if (!PREADY && (wait_cnt_r != 16'hFFFF)) begin
        wait_cnt_r <= wait_cnt_r + 16'd1;
      end
    end
  end

  // APB handshake outputs, registered from the next state.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      psel_r    <= 1'b0;
      penable_r <= 1'b0;
    end else begin
      psel_r    <= (state_s == ST_SETUP) || (state_s == ST_ACCESS);
      penable_r <= (state_s == ST_ACCESS);
    end
  end

  // Address-phase capture; held until the next accepted address phase.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      paddr_r  <= 32'd0;
      pwrite_r <= 1'b0;
      pstrb_r  <= 4'b0000;
      pprot_r  <= 3'b000;
    end else if (cap_s) begin
      paddr_r  <= HADDR;
      pwrite_r <= HWRITE;
      pstrb_r  <= strb_f(HWRITE, HSIZE, HADDR[1:0]);
      pprot_r  <= {~HPROT[0], 1'b0, HPROT[1]};
    end
  end

  // Write data arrives in the AHB data phase, one cycle after the address.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      pwdata_r <= 32'd0;
    end else if (state_r == ST_WDATA) begin
      pwdata_r <= HWDATA;
    end
  end

  // Read data only updates on an error-free read completion.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      hrdata_r <= 32'd0;
    end else if ((state_r == ST_ACCESS) && PREADY && !PSLVERR && !pwrite_r) begin
      hrdata_r <= PRDATA;
    end
  end

  // AHB response, registered from the next state.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      hreadyout_r <= 1'b1;
      hresp_r     <= 1'b0;
    end else begin
      hreadyout_r <= (state_s == ST_IDLE) || (state_s == ST_DONE) || (state_s == ST_ERR2);
      hresp_r     <= (state_s == ST_ERR1) || (state_s == ST_ERR2);
    end
  end

  assign PSEL      = psel_r;
  assign PENABLE   = penable_r;
  assign PWRITE    = pwrite_r;
  assign PADDR     = paddr_r;
  assign PWDATA    = pwdata_r;
  assign PSTRB     = pstrb_r;
  assign PPROT     = pprot_r;
  assign HREADYOUT = hreadyout_r;
  assign HRESP     = hresp_r;
  assign HRDATA    = hrdata_r;

endmodule

// File: tb/tb_ahb_to_apb_bridge.sv
// Scoreboard bench for ahb_to_apb_bridge (TIMEOUT=4): directed AHB transfers push expected
// APB setups and AHB responses; monitors pop and compare when the DUT presents them.
module tb_ahb_to_apb_bridge;

  logic        PCLK;
  logic        PRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;

  assign HREADY = HREADYOUT;

  ahb_to_apb_bridge #(.TIMEOUT(4)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HPROT(HPROT), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [3:0]  strb;
    logic [2:0]  prot;
    logic [31:0] wdata;
    int          acc;
  } apb_exp_t;

  typedef struct {
    logic        resp;
    logic [31:0] rdata;
    int          lat;
  } rsp_exp_t;

  apb_exp_t    apb_q[$];
  rsp_exp_t    rsp_q[$];
  int          total = 0;
  int          bad = 0;
  int          slv_wait = 0;
  logic        slv_err = 1'b0;
  logic [31:0] mem [0:63];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic note_fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: event occurred, none expected", nm);
  endtask

  // APB slave model: ready after slv_wait ACCESS cycles, byte-strobed memory
  initial begin : apb_slave
    int k;
    k = 0;
    forever begin
      @(posedge PCLK);
      #1;
      if (PSEL === 1'b1 && PENABLE === 1'b1) begin
        if (k == slv_wait) begin
          PREADY  = 1'b1;
          PSLVERR = slv_err;
          PRDATA  = mem[PADDR[7:2]];
          if (PWRITE && !slv_err) begin
            for (int b = 0; b < 4; b++) begin
              if (PSTRB[b]) mem[PADDR[7:2]][8*b +: 8] = PWDATA[8*b +: 8];
            end
          end
        end else begin
          PREADY  = 1'b0;
          PSLVERR = 1'b0;
        end
        k++;
      end else begin
        k       = 0;
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
      end
    end
  end

  // AHB response monitor: latency from accepted address phase to HREADYOUT
  initial begin : rsp_mon
    bit       dphase;
    bit       prev_err1;
    int       cnt;
    rsp_exp_t e;
    dphase = 1'b0;
    prev_err1 = 1'b0;
    cnt = 0;
    forever begin
      @(negedge PCLK);
      if (PRESETn !== 1'b1) begin
        dphase = 1'b0;
        prev_err1 = 1'b0;
      end else begin
        if (dphase) begin
          cnt++;
          if (HREADYOUT === 1'b1) begin
            dphase = 1'b0;
            if (rsp_q.size() == 0) begin
              note_fail("unexpected_ahb_response");
            end else begin
              e = rsp_q.pop_front();
              chk("hresp", 32'(HRESP), 32'(e.resp));
              chk("hrdata", HRDATA, e.rdata);
              chk("latency", 32'(cnt), 32'(e.lat));
              if (e.resp) chk("err_first_cycle", 32'(prev_err1), 32'd1);
            end
          end
        end
        if (HSEL && HTRANS[1] && HREADYOUT === 1'b1) begin
          dphase = 1'b1;
          cnt = 0;
        end
        prev_err1 = (HRESP === 1'b1) && (HREADYOUT === 1'b0);
      end
    end
  end

  // APB monitor: setup fields, stability through ACCESS, ACCESS length
  initial begin : apb_mon
    bit       act;
    int       acc;
    apb_exp_t cur;
    act = 1'b0;
    acc = 0;
    forever begin
      @(negedge PCLK);
      if (act && !(PSEL === 1'b1 && PENABLE === 1'b1)) begin
        chk("apb_access_cycles", 32'(acc), 32'(cur.acc));
        act = 1'b0;
      end
      if (PSEL === 1'b1 && PENABLE === 1'b0) begin
        if (apb_q.size() == 0) begin
          note_fail("unexpected_psel");
        end else begin
          cur = apb_q.pop_front();
          act = 1'b1;
          acc = 0;
          chk("setup_paddr", PADDR, cur.addr);
          chk("setup_pwrite", 32'(PWRITE), 32'(cur.wr));
          chk("setup_pstrb", 32'(PSTRB), 32'(cur.strb));
          chk("setup_pprot", 32'(PPROT), 32'(cur.prot));
          if (cur.wr) chk("setup_pwdata", PWDATA, cur.wdata);
        end
      end else if (PSEL === 1'b1 && PENABLE === 1'b1 && act) begin
        acc++;
        chk("access_paddr", PADDR, cur.addr);
        chk("access_pstrb", 32'(PSTRB), 32'(cur.strb));
        if (cur.wr) chk("access_pwdata", PWDATA, cur.wdata);
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic w, input logic [2:0] sz,
                       input logic [31:0] wd, input logic [3:0] pr,
                       input bit has_apb, input logic [3:0] estrb, input logic [2:0] eprot,
                       input int eacc, input bit has_rsp, input logic eresp,
                       input logic [31:0] erdata, input int elat);
    apb_exp_t ae;
    rsp_exp_t re;
    bit ok;
    if (has_apb) begin
      ae.addr = a; ae.wr = w; ae.strb = estrb; ae.prot = eprot; ae.wdata = wd; ae.acc = eacc;
      apb_q.push_back(ae);
    end
    if (has_rsp) begin
      re.resp = eresp; re.rdata = erdata; re.lat = elat;
      rsp_q.push_back(re);
    end
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = w; HSIZE = sz; HPROT = pr;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge PCLK);
      if (HREADYOUT === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) note_fail("addr_accept_timeout");
    @(posedge PCLK);
    #1;
    HWDATA = wd;
  endtask

  task automatic go_idle();
    bit ok;
    HSEL = 1'b0;
    HTRANS = 2'b00;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge PCLK);
      if (rsp_q.size() == 0 && HREADYOUT === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) note_fail("idle_drain_timeout");
    @(posedge PCLK);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit ok;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    mem[8] = 32'hDEAD_BEEF;
    PRESETn = 1'b0; HSEL = 1'b0; HADDR = 32'd0; HTRANS = 2'b00; HWRITE = 1'b0;
    HSIZE = 3'd0; HPROT = 4'd0; HWDATA = 32'd0;
    PRDATA = 32'd0; PREADY = 1'b0; PSLVERR = 1'b0;

    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    chk("rst_psel", 32'(PSEL), 32'd0);
    chk("rst_penable", 32'(PENABLE), 32'd0);
    chk("rst_paddr", PADDR, 32'd0);
    chk("rst_pwrite", 32'(PWRITE), 32'd0);
    chk("rst_pwdata", PWDATA, 32'd0);
    chk("rst_pstrb", 32'(PSTRB), 32'd0);
    chk("rst_pprot", 32'(PPROT), 32'd0);
    chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    chk("rst_hresp", 32'(HRESP), 32'd0);
    chk("rst_hrdata", HRDATA, 32'd0);
    @(posedge PCLK);
    #1;
    PRESETn = 1'b1;
    @(posedge PCLK);
    #1;

    // word write, read-back
    issue(32'h10, 1'b1, 3'd2, 32'hA5A5_1234, 4'b0011, 1, 4'b1111, 3'b001, 1, 1, 1'b0, 32'h0, 4);
    go_idle();
    issue(32'h10, 1'b0, 3'd2, 32'h0, 4'b0000, 1, 4'b0000, 3'b100, 1, 1, 1'b0, 32'hA5A5_1234, 3);
    go_idle();

    // byte then halfword write back-to-back, read-back merges lanes
    issue(32'h13, 1'b1, 3'd0, 32'h7700_0000, 4'b0010, 1, 4'b1000, 3'b101, 1, 1, 1'b0, 32'hA5A5_1234, 4);
    issue(32'h12, 1'b1, 3'd1, 32'hBEEF_0000, 4'b0010, 1, 4'b1100, 3'b101, 1, 1, 1'b0, 32'hA5A5_1234, 4);
    issue(32'h10, 1'b0, 3'd2, 32'h0, 4'b0011, 1, 4'b0000, 3'b001, 1, 1, 1'b0, 32'hBEEF_1234, 3);
    go_idle();

    // misaligned halfword, then HSIZE=3 captured in ERR2
    issue(32'h01, 1'b1, 3'd1, 32'h0, 4'b0011, 0, 4'b0000, 3'b000, 0, 1, 1'b1, 32'hBEEF_1234, 2);
    issue(32'h10, 1'b0, 3'd3, 32'h0, 4'b0011, 0, 4'b0000, 3'b000, 0, 1, 1'b1, 32'hBEEF_1234, 2);
    go_idle();

    // three wait states then slave error: HRDATA holds
    slv_wait = 3;
    slv_err = 1'b1;
    issue(32'h20, 1'b0, 3'd2, 32'h0, 4'b0011, 1, 4'b0000, 3'b001, 4, 1, 1'b1, 32'hBEEF_1234, 7);
    go_idle();
    slv_err = 1'b0;

    // PREADY never rises: timeout after four ACCESS cycles
    slv_wait = 1000;
    issue(32'h30, 1'b0, 3'd2, 32'h0, 4'b0011, 1, 4'b0000, 3'b001, 4, 1, 1'b1, 32'hBEEF_1234, 7);
    go_idle();
    slv_wait = 0;

    // back-to-back read, write, read
    issue(32'h10, 1'b0, 3'd2, 32'h0, 4'b0011, 1, 4'b0000, 3'b001, 1, 1, 1'b0, 32'hBEEF_1234, 3);
    issue(32'h14, 1'b1, 3'd2, 32'h1234_5678, 4'b0011, 1, 4'b1111, 3'b001, 1, 1, 1'b0, 32'hBEEF_1234, 4);
    issue(32'h14, 1'b0, 3'd2, 32'h0, 4'b0011, 1, 4'b0000, 3'b001, 1, 1, 1'b0, 32'h1234_5678, 3);
    go_idle();

    // reset during ACCESS abandons the transfer
    slv_wait = 1000;
    issue(32'h10, 1'b0, 3'd2, 32'h0, 4'b0000, 1, 4'b0000, 3'b100, 1, 0, 1'b0, 32'h0, 0);
    HSEL = 1'b0;
    HTRANS = 2'b00;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (PENABLE === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge PCLK);
      #1;
    end
    if (!ok) note_fail("access_not_reached");
    PRESETn = 1'b0;
    @(posedge PCLK);
    #1;
    PRESETn = 1'b1;
    slv_wait = 0;
    @(negedge PCLK);
    chk("midrst_psel", 32'(PSEL), 32'd0);
    chk("midrst_penable", 32'(PENABLE), 32'd0);
    chk("midrst_hreadyout", 32'(HREADYOUT), 32'd1);
    chk("midrst_hresp", 32'(HRESP), 32'd0);
    chk("midrst_hrdata", HRDATA, 32'd0);
    @(posedge PCLK);
    #1;
    issue(32'h14, 1'b0, 3'd2, 32'h0, 4'b0011, 1, 4'b0000, 3'b001, 1, 1, 1'b0, 32'h1234_5678, 3);
    go_idle();

    repeat (3) @(negedge PCLK);
    chk("apb_queue_drained", 32'(apb_q.size()), 32'd0);
    chk("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
